// File: rtl/lsu_hs.sv
// rtl/lsu_hs.sv - RV32I load/store unit with valid/ready handshake memory port
module lsu_hs #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic        o_rsp_timeout,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t      state, state_nxt;
    logic        wen_q, trap_q, timeout_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q, cnt_q;
    logic        illegal_in, misal_in, bad_in, timeout_hit;
    logic [31:0] shifted, load_val, lane_wdata;
    logic [3:0]  lane_mask;

    // Decode of the incoming request; bad requests never reach memory.
    always_comb begin
        if (i_req_wen)
            illegal_in = (i_req_funct3 >= 3'd3);
        else
            illegal_in = (i_req_funct3 == 3'd3) || (i_req_funct3[2:1] == 2'b11);
        case (i_req_funct3[1:0])
            2'b01:   misal_in = i_req_addr[0];
            2'b10:   misal_in = (i_req_addr[1:0] != 2'b00);
            default: misal_in = 1'b0;
        endcase
        bad_in = illegal_in || misal_in;
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_req_valid) state_nxt = bad_in ? RSP : REQ;
            REQ: begin
                if (timeout_hit)      state_nxt = RSP;
                else if (i_mem_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (timeout_hit || i_mem_rvalid) state_nxt = RSP;
            end
            RSP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            wen_q     <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            cnt_q     <= 32'd0;
            trap_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_req_valid) begin
                wen_q     <= i_req_wen;
                f3_q      <= i_req_funct3;
                addr_q    <= i_req_addr;
                wdata_q   <= i_req_wdata;
                rdata_q   <= 32'd0;
                cnt_q     <= 32'd0;
                trap_q    <= bad_in;
                timeout_q <= 1'b0;
            end else if (state == REQ || state == WAIT) begin
                cnt_q <= cnt_q + 32'd1;
                if (timeout_hit) begin
                    trap_q    <= 1'b1;
                    timeout_q <= 1'b1;
                end else if (state == WAIT && i_mem_rvalid) begin
                    rdata_q <= i_mem_rdata;
                end
            end
        end
    end

    // Byte-lane placement for the memory side and extraction for loads.
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << addr_q[1:0];
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    load_val = shifted;
            3'd4:    load_val = {24'd0, shifted[7:0]};
            3'd5:    load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    assign o_req_ready   = (state == IDLE);
    assign o_mem_valid   = (state == REQ);
    assign o_mem_addr    = {addr_q[31:2], 2'b00};
    assign o_mem_ren     = (state == REQ) && !wen_q;
    assign o_mem_wen     = (state == REQ) && wen_q;
    assign o_mem_mask    = (state == REQ) ? lane_mask : 4'b0000;
    assign o_mem_wdata   = (state == REQ) ? lane_wdata : 32'd0;
    assign o_rsp_valid   = (state == RSP);
    assign o_rsp_trap    = (state == RSP) && trap_q;
    assign o_rsp_timeout = (state == RSP) && timeout_q;
    assign o_rsp_rdata   = (state == RSP && !trap_q && !wen_q) ? load_val : 32'd0;
endmodule

// File: tb/tb_lsu_hs.sv
// tb/tb_lsu_hs.sv - scoreboard bench for lsu_hs with randomized memory timing
module tb_lsu_hs;
    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid, o_req_ready, i_req_wen;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr, i_req_wdata;
    logic        o_rsp_valid, o_rsp_trap, o_rsp_timeout;
    logic [31:0] o_rsp_rdata;
    logic        o_mem_valid, i_mem_ready, o_mem_ren, o_mem_wen, i_mem_rvalid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [3:0]  o_mem_mask;

    lsu_hs #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wen(i_req_wen), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_trap(o_rsp_trap), .o_rsp_timeout(o_rsp_timeout),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          rdly, vdly;
        bit          to;
    } txn_t;
    typedef struct { logic trap, tmo; logic [31:0] rdata; int cyc; } rsp_t;
    typedef struct { logic [31:0] addr, wdata; logic [3:0] mask; logic wen; } mexp_t;

    rsp_t  rsp_q[$];
    mexp_t mem_q[$];
    txn_t  plan_q[$];
    int    cyc = 0;
    int    errs = 0;
    int    checks = 0;
    bit    mem_manual = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-level view of a RV32I access.
    function automatic void model(input txn_t t, input int t0, output rsp_t r, output mexp_t m,
                                  output bit acc);
        int n, off;
        bit illegal;
        logic [31:0] v;
        n = 1 << t.f3[1:0];
        off = int'(t.addr[1:0]);
        illegal = t.wen ? (t.f3 >= 3) : (t.f3 == 3 || t.f3 >= 6);
        acc = !illegal && (off % n == 0);
        m.addr = {t.addr[31:2], 2'b00};
        m.wen  = t.wen;
        m.mask = 4'(((1 << n) - 1) << off);
        for (int k = 0; k < 4; k++) m.wdata[8*k +: 8] = t.wdata[8*(k % n) +: 8];
        v = 32'd0;
        if (acc) begin
            for (int j = 0; j < n; j++) v[8*j +: 8] = t.rdata[8*(off + j) +: 8];
            if (!t.f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        end
        r.trap  = !acc || t.to;
        r.tmo   = acc && t.to;
        r.rdata = (acc && !t.to && !t.wen) ? v : 32'd0;
        r.cyc   = !acc ? t0 + 1 : (t.to ? t0 + 1 + TO : t0 + 3 + t.rdly + t.vdly);
    endfunction

    function automatic txn_t gen();
        txn_t t;
        int   sel;
        t.wen = 1'($urandom);
        if ($urandom_range(7, 0) == 0) t.f3 = 3'($urandom);
        else if (t.wen) t.f3 = 3'($urandom_range(2, 0));
        else begin
            sel = int'($urandom_range(4, 0));
            t.f3 = (sel > 2) ? 3'(sel + 1) : 3'(sel);
        end
        t.addr = $urandom;
        if ($urandom_range(3, 0) != 0) begin
            if (t.f3[1:0] == 2'b01) t.addr[0] = 1'b0;
            if (t.f3[1:0] == 2'b10) t.addr[1:0] = 2'b00;
        end
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.rdly  = int'($urandom_range(3, 0));
        t.vdly  = int'($urandom_range(2, 0));
        t.to    = ($urandom_range(19, 0) == 0);
        return t;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, o_req_ready, 1);
        chk({tag, "_mem_valid"}, o_mem_valid, 0);
        chk({tag, "_mem_ren"}, o_mem_ren, 0);
        chk({tag, "_mem_wen"}, o_mem_wen, 0);
        chk({tag, "_mem_mask"}, o_mem_mask, 0);
        chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
        chk({tag, "_rsp_trap"}, o_rsp_trap, 0);
        chk({tag, "_rsp_timeout"}, o_rsp_timeout, 0);
        chk({tag, "_rsp_rdata"}, o_rsp_rdata, 0);
    endtask

    // Response monitor.
    initial begin
        rsp_t e;
        forever begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = rsp_q.pop_front();
                    chk("rsp_trap", o_rsp_trap, e.trap);
                    chk("rsp_timeout", o_rsp_timeout, e.tmo);
                    chk("rsp_rdata", o_rsp_rdata, e.rdata);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else begin
                chk("rsp_idle_zero", {o_rsp_trap, o_rsp_timeout, o_rsp_rdata}, 0);
            end
        end
    end

    // Memory-port monitor: request fields must match and hold for every REQ cycle.
    initial begin
        mexp_t m;
        bit    was = 0;
        forever begin
            @(negedge i_clk);
            chk("mem_ren_wen_excl", o_mem_ren & o_mem_wen, 0);
            if (o_mem_valid) begin
                if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
                else begin
                    m = mem_q[0];
                    chk("mem_addr", o_mem_addr, m.addr);
                    chk("mem_mask", o_mem_mask, m.mask);
                    chk("mem_wen", o_mem_wen, m.wen);
                    chk("mem_ren", o_mem_ren, !m.wen);
                    if (m.wen) chk("mem_wdata", o_mem_wdata, m.wdata);
                end
                was = 1;
            end else begin
                chk("mem_idle_zero", {o_mem_ren, o_mem_wen, o_mem_mask}, 0);
                if (was && mem_q.size() != 0) void'(mem_q.pop_front());
                was = 0;
            end
        end
    end

    // Memory responder following each transaction's planned timing.
    initial begin
        txn_t p;
        int   w;
        i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        forever begin
            @(negedge i_clk);
            if (!mem_manual) begin
                i_mem_ready = 0; i_mem_rvalid = 0;
                if (o_mem_valid) begin
                    if (plan_q.size() == 0) chk("mem_no_plan", 1, 0);
                    else begin
                        p = plan_q.pop_front();
                        if (p.to) begin
                            w = 0;
                            while (o_mem_valid && w < 40) begin @(negedge i_clk); w++; end
                            i_mem_rvalid = 1; i_mem_rdata = $urandom;
                        end else begin
                            repeat (p.rdly) @(negedge i_clk);
                            // rvalid alongside ready must be ignored
                            i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = ~p.rdata;
                            @(negedge i_clk);
                            i_mem_ready = 0; i_mem_rvalid = 0;
                            repeat (p.vdly) @(negedge i_clk);
                            i_mem_rvalid = 1; i_mem_rdata = p.rdata;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic wait_ready();
        int w = 0;
        while (!o_req_ready && w < 60) begin @(negedge i_clk); w++; end
        chk("req_ready_wait", o_req_ready, 1);
    endtask

    initial begin
        txn_t  dir[8];
        txn_t  t;
        rsp_t  r;
        mexp_t m;
        bit    acc;
        int    w;
        dir[0] = '{wen:0, f3:3'd0, addr:32'h1003, wdata:32'h0, rdata:32'h80FF_FF00, rdly:0, vdly:0, to:0};
        dir[1] = '{wen:1, f3:3'd1, addr:32'h2002, wdata:32'h1234_ABCD, rdata:32'h0, rdly:0, vdly:0, to:0};
        dir[2] = '{wen:0, f3:3'd2, addr:32'h1001, wdata:32'h0, rdata:32'h0, rdly:0, vdly:0, to:0};
        dir[3] = '{wen:0, f3:3'd5, addr:32'h0002, wdata:32'h0, rdata:32'hF00D_0000, rdly:3, vdly:0, to:0};
        dir[4] = '{wen:0, f3:3'd2, addr:32'h0100, wdata:32'h0, rdata:32'h0, rdly:0, vdly:0, to:1};
        dir[5] = '{wen:0, f3:3'd3, addr:32'h0000, wdata:32'h0, rdata:32'h0, rdly:0, vdly:0, to:0};
        dir[6] = '{wen:1, f3:3'd3, addr:32'h0010, wdata:32'h0, rdata:32'h0, rdly:0, vdly:0, to:0};
        dir[7] = '{wen:1, f3:3'd0, addr:32'h3001, wdata:32'h0000_0055, rdata:32'h0, rdly:1, vdly:2, to:0};

        i_rst = 1; i_req_valid = 0; i_req_wen = 0; i_req_funct3 = 0;
        i_req_addr = 0; i_req_wdata = 0;
        repeat (2) @(negedge i_clk);
        check_reset("reset");
        i_rst = 0;

        for (int i = 0; i < 158; i++) begin
            t = (i < 8) ? dir[i] : gen();
            repeat ($urandom_range(2, 0)) @(negedge i_clk);
            wait_ready();
            i_req_valid = 1; i_req_wen = t.wen; i_req_funct3 = t.f3;
            i_req_addr = t.addr; i_req_wdata = t.wdata;
            model(t, cyc, r, m, acc);
            rsp_q.push_back(r);
            if (acc) begin mem_q.push_back(m); plan_q.push_back(t); end
            @(negedge i_clk);
            i_req_valid = 0; i_req_wen = 1'($urandom); i_req_funct3 = 3'($urandom);
            i_req_addr = $urandom; i_req_wdata = $urandom;
        end

        w = 0;
        while ((rsp_q.size() != 0 || plan_q.size() != 0) && w < 100) begin @(negedge i_clk); w++; end
        chk("drain_rsp", rsp_q.size(), 0);

        // Reset while an access sits in WAIT; the late response must vanish.
        mem_manual = 1;
        repeat (2) @(negedge i_clk);
        wait_ready();
        i_req_valid = 1; i_req_wen = 0; i_req_funct3 = 3'd2; i_req_addr = 32'h40;
        mem_q.push_back('{addr:32'h40, wdata:32'h0, mask:4'hF, wen:1'b0});
        @(negedge i_clk);
        i_req_valid = 0; i_mem_ready = 1; i_mem_rvalid = 0;
        @(negedge i_clk);
        chk("wait_mem_valid", o_mem_valid, 0);
        chk("wait_req_ready", o_req_ready, 0);
        i_mem_ready = 0; i_rst = 1;
        @(negedge i_clk);
        check_reset("mid_reset");
        i_rst = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_mem_rvalid = 0;
        check_reset("post_reset");
        repeat (4) @(negedge i_clk);
        chk("post_reset_idle", o_req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
